// File: rtl/fermat_inverse_mod_p.sv
// Sequential modular inverse over GF(P): a^(P-2) mod P by right-to-left square-and-multiply,
// one exponent bit per cycle, with Barrett-reduced products and a start/done handshake.
module fermat_inverse_mod_p #(
  parameter int P = 17,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] din_a,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] dout_r
);

  localparam int E     = P - 2;
  localparam int EBITS = $clog2(P - 1);
  localparam int TW    = 2 * W;
  localparam int PW    = 3 * W + 1;

  localparam logic [PW-1:0]    MU_V   = PW'((4 ** W) / P);
  localparam logic [TW-1:0]    P_T    = TW'(P);
  localparam logic [W-1:0]     P_W    = W'(P);
  localparam logic [EBITS-1:0] E_V    = EBITS'(E);
  localparam logic [EBITS-1:0] LAST_I = EBITS'(EBITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Barrett product: q underestimates t/P by at most one, so a single correction suffices.
  function automatic logic [W-1:0] modmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [TW-1:0] t;
    logic [PW-1:0] qt;
    logic [TW-1:0] q;
    logic [TW-1:0] r;
    t  = TW'(x) * TW'(y);
    qt = PW'(t) * MU_V;
    q  = TW'(qt >> TW);
    r  = t - q * P_T;
    if (r >= P_T) r = r - P_T;
    return r[W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [W-1:0]      res_q, res_d;
  logic [W-1:0]      base_q, base_d;
  logic [EBITS-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [W-1:0]      dout_q, dout_d;

  logic [W-1:0]      a_red;
  logic [W-1:0]      mm_res;
  logic [W-1:0]      mm_base;
  logic              e_bit;
  logic [W-1:0]      res_next;

  // 2^W - 1 < 2P, so one conditional subtraction fully reduces the operand.
  assign a_red    = (din_a >= P_W) ? (din_a - P_W) : din_a;
  assign mm_res   = modmul(res_q, base_q);
  assign mm_base  = modmul(base_q, base_q);
  assign e_bit    = |(E_V & (EBITS'(1) << cnt_q));
  assign res_next = e_bit ? mm_res : res_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          res_d   = W'(1);
          base_d  = a_red;
          cnt_d   = '0;
          err_d   = (a_red == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = res_next;
        base_d = mm_base;
        cnt_d  = cnt_q + EBITS'(1);
        if (cnt_q == LAST_I) begin
          dout_d  = err_q ? '0 : res_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign dout_r = dout_q;

endmodule
